wb_rr_arb: RTL
==============

WB_RR_ARB -- requirements
Module: wb_rr_arb

Interface
REQ-001 Parameters, SHALL be: nm, 3, master count (>=2); aw, 32, address width; dw, 32, data width; nb_w, dw/8, byte-select width; tmo_w, 8, timeout counter width.
REQ-002 wb_clk_i  in  1  single clock; all state on rising edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 wbm_adr_i  in  nm*aw  master addresses, master i at slice i.
REQ-005 wbm_dat_i  in  nm*dw  master write data.
REQ-006 wbm_sel_i  in  nm*nb_w  master byte selects.
REQ-007 wbm_cti_i  in  nm*3  master cycle type.
REQ-008 wbm_bte_i  in  nm*2  master burst type.
REQ-009 wbm_we_i, wbm_cyc_i, wbm_stb_i  in  nm each  per-master write enable, cycle, strobe.
REQ-010 wbm_dat_o  out  dw  read data, broadcast to all masters.
REQ-011 wbm_ack_o, wbm_err_o, wbm_rty_o  out  nm each  per-master termination.
REQ-012 wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o, wbs_we_o  out  aw, dw, nb_w, 3, 2, 1  granted master's fields.
REQ-013 wbs_cyc_o, wbs_stb_o  out  1 each  slave cycle and strobe.
REQ-014 wbs_dat_i  in  dw  slave read data.
REQ-015 wbs_ack_i, wbs_err_i, wbs_rty_i  in  1 each  slave termination.
REQ-016 gnt_o  out  nm  registered one-hot grant; all-zero when idle.

Function
REQ-017 States SHALL be IDLE (gnt_o=0) and BUSY (exactly one gnt_o bit set, index g).
REQ-018 Request i SHALL be wbm_cyc_i[i]; arbitration SHALL occur only in IDLE.
REQ-019 Round-robin: search from index (last+1) mod nm upward with wrap; first requester wins; last = most recently granted index.
REQ-020 Grant latency: requester seen in IDLE at edge n SHALL have gnt_o set and its cycle on the slave port from cycle n+1.
REQ-021 In BUSY, wbs_* fields, cyc, stb SHALL combinationally follow master g; in IDLE wbs_cyc_o/wbs_stb_o SHALL be 0, other wbs_* outputs 0.
REQ-022 wbm_ack_o[g]/err/rty SHALL be wbs_ack_i/err/rty combinationally; all non-granted bits SHALL be 0; wbm_dat_o = wbs_dat_i always.
REQ-023 Grant SHALL be held while wbm_cyc_i[g]=1, covering bursts (cti 001/010) and back-to-back classic cycles.
REQ-024 BUSY->IDLE at the edge where wbm_cyc_i[g]=0 is sampled; last<=g; gnt_o SHALL be 0 for at least one cycle between any two grants.
REQ-025 Timeout counter (tmo_w bits): cleared when wbs_stb_o=0 or any slave termination is high, else +1 per cycle; never wraps.
REQ-026 When counter = 2^tmo_w-1 with stb high and no termination: wbm_err_o[g]=1 and wbs_cyc_o=wbs_stb_o=0 that cycle; next state IDLE, last<=g, counter<=0.
REQ-027 A timed-out master still holding cyc SHALL re-arbitrate normally at lowest priority.
REQ-028 Termination and cyc drop in same cycle: termination passes through, then release per REQ-024.
REQ-029 Requests arriving during BUSY SHALL wait; no request SHALL be lost while cyc stays high.

Reset
REQ-030 On wb_rst_i=1, immediately: state IDLE, gnt_o=0, last=nm-1 (master 0 wins first), counter=0, wbs_cyc_o=wbs_stb_o=0, all wbm_ack/err/rty_o=0.
REQ-031 Reset mid-transaction SHALL drop the slave cycle asynchronously without terminating the master; after release, arbitration restarts per REQ-030.

Verification (nm=3, tmo_w=4)
REQ-032 After reset, cyc=3'b111 at same edge -> gnt_o=001 next cycle; m0 releases -> gap cycle -> gnt_o=010; then 100; then 001.
REQ-033 m1 4-beat incrementing burst (cti 010,010,010,111) with m0 requesting -> gnt_o stays 010 through 4 acks; m0 granted after m1 drops cyc plus one idle cycle.
REQ-034 Slave never acks m2 -> wbm_err_o[2]=1 on 16th stb cycle, wbs_cyc_o=0 that cycle; gnt_o=000 next cycle; pending m0 then granted.
REQ-035 Only m1 requesting, repeated classic writes sel=4'b0011 -> wbs_sel_o=0011, wbs_we_o=1, wbm_ack_o=010 per slave ack; wbm_ack_o[0], [2] never 1.
REQ-036 Assert wb_rst_i mid-burst of m2 -> wbs_cyc_o, gnt_o go 0 without clock edge; after deassert with cyc=3'b101 -> m0 granted first.

Source files
------------

// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone arbiter: nm masters share one slave port, with a
// per-grant watchdog that errors out a stalled strobe and releases the bus.
module wb_rr_arb #(
  parameter int unsigned nm    = 3,
  parameter int unsigned aw    = 32,
  parameter int unsigned dw    = 32,
  parameter int unsigned nb_w  = dw / 8,
  parameter int unsigned tmo_w = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [nm*aw-1:0]   wbm_adr_i,
  input  logic [nm*dw-1:0]   wbm_dat_i,
  input  logic [nm*nb_w-1:0] wbm_sel_i,
  input  logic [nm*3-1:0]    wbm_cti_i,
  input  logic [nm*2-1:0]    wbm_bte_i,
  input  logic [nm-1:0]      wbm_we_i,
  input  logic [nm-1:0]      wbm_cyc_i,
  input  logic [nm-1:0]      wbm_stb_i,
  output logic [dw-1:0]      wbm_dat_o,
  output logic [nm-1:0]      wbm_ack_o,
  output logic [nm-1:0]      wbm_err_o,
  output logic [nm-1:0]      wbm_rty_o,
  output logic [aw-1:0]      wbs_adr_o,
  output logic [dw-1:0]      wbs_dat_o,
  output logic [nb_w-1:0]    wbs_sel_o,
  output logic [2:0]         wbs_cti_o,
  output logic [1:0]         wbs_bte_o,
  output logic               wbs_we_o,
  output logic               wbs_cyc_o,
  output logic               wbs_stb_o,
  input  logic [dw-1:0]      wbs_dat_i,
  input  logic               wbs_ack_i,
  input  logic               wbs_err_i,
  input  logic               wbs_rty_i,
  output logic [nm-1:0]      gnt_o
);

  localparam int unsigned IW = (nm > 1) ? $clog2(nm) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [nm-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [tmo_w-1:0] tmo_q, tmo_d;

  logic          m_cyc, m_stb, term, tmo_hit, found;
  logic [IW-1:0] g_idx, win_idx;
  int unsigned   cand;

  // gnt_q is all-zero in IDLE, so the AND-OR mux also zeroes the slave fields.
  always_comb begin
    m_cyc     = 1'b0;
    m_stb     = 1'b0;
    g_idx     = '0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbs_we_o  = 1'b0;
    for (int unsigned i = 0; i < nm; i++) begin
      if (gnt_q[i]) begin
        g_idx     = IW'(i);
        m_cyc     = wbm_cyc_i[i];
        m_stb     = wbm_stb_i[i];
        wbs_adr_o = wbm_adr_i[i*aw +: aw];
        wbs_dat_o = wbm_dat_i[i*dw +: dw];
        wbs_sel_o = wbm_sel_i[i*nb_w +: nb_w];
        wbs_cti_o = wbm_cti_i[i*3 +: 3];
        wbs_bte_o = wbm_bte_i[i*2 +: 2];
        wbs_we_o  = wbm_we_i[i];
      end
    end
  end

  always_comb begin
    term      = wbs_ack_i | wbs_err_i | wbs_rty_i;
    tmo_hit   = (state_q == BUSY) && m_stb && (tmo_q == '1) && !term;
    wbs_cyc_o = m_cyc & ~tmo_hit;
    wbs_stb_o = m_stb & ~tmo_hit;
    wbm_ack_o = gnt_q & {nm{wbs_ack_i}};
    wbm_err_o = gnt_q & {nm{wbs_err_i | tmo_hit}};
    wbm_rty_o = gnt_q & {nm{wbs_rty_i}};
    wbm_dat_o = wbs_dat_i;
    gnt_o     = gnt_q;
  end

  // Search starts just past the last winner, so it naturally ranks lowest.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= nm; k++) begin
      cand = (32'(last_q) + k) % nm;
      if (!found && wbm_cyc_i[cand]) begin
        found   = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (found) begin
          state_d        = BUSY;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
        end
      end
      BUSY: begin
        if (tmo_hit || !m_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = g_idx;
          tmo_d   = '0;
        end else if (!m_stb || term) begin
          tmo_d = '0;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        tmo_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(nm - 1);
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
